// File: rtl/inference_sequencer.sv
// inference_sequencer
//   Runs a batch of samples through the encoding/similarity datapath. For each
//   sample it waits for the memories to be loaded and for room in the result
//   FIFO, pulses dp_reset, presents the sample's feature base address, then
//   captures the checker's max_index/max_val into a first-word fall-through
//   result FIFO that the host drains with res_valid/res_ready.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   start, num_samples             batch launch (IDLE only) and batch size
//   write_done                     memories loaded (level, checked in WAIT_LOAD)
//   sample_done, max_val, max_index  checker done pulse and result
//   dp_reset, feature_base         per-sample datapath reset and base address
//   busy, batch_done               batch in progress / end-of-batch pulse
//   res_valid, res_ready           result FIFO handshake
//   res_sample, res_index, res_val, res_err  FIFO head entry
//
// Optional feature: define INFERENCE_SEQ_TIMEOUT_EN to enable a RUN watchdog
// that pushes an error entry after TIMEOUT_CYCLES without sample_done.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start
// WAIT_LOAD | waiting for write_done and a free FIFO slot
// LAUNCH    | one-cycle dp_reset for the current sample
// RUN       | waiting for sample_done (or watchdog) to capture the result
// DONE      | one-cycle batch_done pulse
module inference_sequencer #(
   parameter int SAMPLE_WIDTH   = 8,
   parameter int FEA_ADDR_WIDTH = 8,
   parameter int SAMPLE_STRIDE  = 4,
   parameter int RES_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [SAMPLE_WIDTH-1:0]   num_samples,
   input  logic                      write_done,
   input  logic                      sample_done,
   input  logic [15:0]               max_val,
   input  logic [15:0]               max_index,
   output logic                      dp_reset,
   output logic [FEA_ADDR_WIDTH-1:0] feature_base,
   output logic                      busy,
   output logic                      batch_done,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [SAMPLE_WIDTH-1:0]   res_sample,
   output logic [15:0]               res_index,
   output logic [15:0]               res_val,
   output logic                      res_err
);

   localparam int PW = $clog2(RES_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_LOAD, S_LAUNCH, S_RUN, S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [SAMPLE_WIDTH-1:0]   count_q, idx_q;
   logic [FEA_ADDR_WIDTH-1:0] base_q;
   logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]             fill_q;
   logic                      fifo_full, push, pop, last, timeout;

   logic [SAMPLE_WIDTH-1:0]   sample_mem [RES_DEPTH];
   logic [15:0]               index_mem  [RES_DEPTH];
   logic [15:0]               val_mem    [RES_DEPTH];

`ifdef INFERENCE_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmr_q;
   logic          err_mem [RES_DEPTH];

   // Down-counter loaded in LAUNCH so it is fresh on every RUN entry;
   // terminal count on the TIMEOUT_CYCLES-th RUN cycle.
   always_ff @(posedge clk) begin
      if (reset)
         tmr_q <= '0;
      else if (state_q == S_LAUNCH)
         tmr_q <= TW'(TIMEOUT_CYCLES - 1);
      else if (state_q == S_RUN && tmr_q != '0)
         tmr_q <= tmr_q - TW'(1);
   end

   assign timeout = (state_q == S_RUN) && (tmr_q == '0);

   always_ff @(posedge clk) begin
      if (push)
         err_mem[wr_ptr_q] <= ~sample_done;
   end

   assign res_err = res_valid ? err_mem[rd_ptr_q] : 1'b0;
`else
   assign timeout = 1'b0;
   assign res_err = 1'b0;
`endif

   assign fifo_full = (fill_q == CW'(RES_DEPTH));
   assign push      = (state_q == S_RUN) && (sample_done || timeout);
   assign pop       = res_valid && res_ready;
   assign last      = (idx_q == count_q - SAMPLE_WIDTH'(1));

   always_comb begin
      state_d    = state_q;
      dp_reset   = 1'b0;
      busy       = 1'b0;
      batch_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start)
               state_d = (num_samples != '0) ? S_WAIT_LOAD : S_DONE;
         end
         S_WAIT_LOAD: begin
            busy = 1'b1;
            if (write_done && !fifo_full)
               state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            busy     = 1'b1;
            dp_reset = 1'b1;
            state_d  = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (push)
               state_d = last ? S_DONE : S_WAIT_LOAD;
         end
         S_DONE: begin
            batch_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // base tracks idx*SAMPLE_STRIDE incrementally; the natural wrap of the
   // adder gives the modulo-2^FEA_ADDR_WIDTH behaviour.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         idx_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && start) begin
            count_q <= num_samples;
            idx_q   <= '0;
            base_q  <= '0;
         end else if (push) begin
            if (last) begin
               idx_q  <= '0;
               base_q <= '0;
            end else begin
               idx_q  <= idx_q + SAMPLE_WIDTH'(1);
               base_q <= base_q + FEA_ADDR_WIDTH'(SAMPLE_STRIDE);
            end
         end
      end
   end

   assign feature_base = base_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !pop)
            fill_q <= fill_q + CW'(1);
         else if (pop && !push)
            fill_q <= fill_q - CW'(1);
      end
   end

   // Timeout entries carry zero index/value.
   always_ff @(posedge clk) begin
      if (push) begin
         sample_mem[wr_ptr_q] <= idx_q;
         index_mem[wr_ptr_q]  <= sample_done ? max_index : 16'h0000;
         val_mem[wr_ptr_q]    <= sample_done ? max_val   : 16'h0000;
      end
   end

   assign res_valid  = (fill_q != '0);
   assign res_sample = res_valid ? sample_mem[rd_ptr_q] : '0;
   assign res_index  = res_valid ? index_mem[rd_ptr_q]  : 16'h0000;
   assign res_val    = res_valid ? val_mem[rd_ptr_q]    : 16'h0000;

endmodule

// File: tb/tb_inference_sequencer.sv
// Testbench for inference_sequencer: a responder models the similarity checker
// and queues the expected result for each launch; a monitor pops and compares
// whenever the host side accepts a FIFO entry.
module tb_inference_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  num_samples = '0;
   logic        write_done = 1'b1;
   logic        sample_done = 1'b0;
   logic [15:0] max_val = '0;
   logic [15:0] max_index = '0;
   logic        dp_reset, busy, batch_done, res_valid, res_err;
   logic        res_ready = 1'b0;
   logic [7:0]  feature_base, res_sample;
   logic [15:0] res_index, res_val;

   always #5 clk = ~clk;

   inference_sequencer #(
      .SAMPLE_WIDTH(8), .FEA_ADDR_WIDTH(8), .SAMPLE_STRIDE(4),
      .RES_DEPTH(4), .TIMEOUT_CYCLES(50)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
      .write_done(write_done), .sample_done(sample_done), .max_val(max_val),
      .max_index(max_index), .dp_reset(dp_reset), .feature_base(feature_base),
      .busy(busy), .batch_done(batch_done), .res_valid(res_valid),
      .res_ready(res_ready), .res_sample(res_sample), .res_index(res_index),
      .res_val(res_val), .res_err(res_err)
   );

   typedef struct packed {
      logic [7:0]  s;
      logic [15:0] idx;
      logic [15:0] val;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   launches_total = 0;
   int   batch_base = 0;
   int   bd_cnt = 0;
   int   resp_delay = 10;
   logic abort_resp = 1'b0;
   logic no_resp = 1'b0;
   logic flush_q = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input logic [7:0] n);
      batch_base  = launches_total;
      num_samples = n;
      start       = 1'b1;
      step(1);
      start       = 1'b0;
   endtask

   task automatic wait_bd(input int maxc);
      logic found;
      found = 1'b0;
      for (int i = 0; i < maxc && !found; i++) begin
         @(negedge clk);
         if (batch_done) found = 1'b1;
      end
      check("batch_done_seen", {31'd0, found}, 32'd1);
   endtask

   // Checker model: answers each launch after resp_delay cycles with a
   // result derived from the global launch number.
   initial begin
      int   k;
      logic aborted;
      logic [7:0] eb;
      forever begin
         @(negedge clk);
         if (dp_reset) begin
            k  = launches_total - batch_base;
            eb = 8'(k * 4);
            check("feature_base", {24'd0, feature_base}, {24'd0, eb});
            launches_total++;
            if (no_resp) begin
               exp_q.push_back('{s: 8'(k), idx: 16'h0, val: 16'h0, err: 1'b1});
            end else begin
               aborted = 1'b0;
               for (int i = 0; i < resp_delay; i++) begin
                  @(posedge clk);
                  if (abort_resp) aborted = 1'b1;
               end
               if (!aborted) begin
                  #1;
                  sample_done = 1'b1;
                  max_index   = 16'h0010 + 16'(launches_total);
                  max_val     = 16'hF000 - 16'(launches_total * 7);
                  exp_q.push_back('{s: 8'(k), idx: max_index, val: max_val, err: 1'b0});
                  @(posedge clk);
                  #1;
                  sample_done = 1'b0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (flush_q) begin
         exp_q.delete();
      end else if (res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got sample %0d with no entry expected", res_sample);
         end else begin
            e = exp_q.pop_front();
            check("res_sample", {24'd0, res_sample}, {24'd0, e.s});
            check("res_index", {16'd0, res_index}, {16'd0, e.idx});
            check("res_val", {16'd0, res_val}, {16'd0, e.val});
            check("res_err", {31'd0, res_err}, {31'd0, e.err});
         end
      end
      if (batch_done) bd_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int bd0, n;
      logic seen;

      // Reset state
      step(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_dp_reset", {31'd0, dp_reset}, 32'd0);
      check("rst_batch_done", {31'd0, batch_done}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_feature_base", {24'd0, feature_base}, 32'd0);
      check("rst_res_err", {31'd0, res_err}, 32'd0);

      // Basic batch of 3
      step(1);
      res_ready = 1'b1;
      bd0 = bd_cnt;
      do_start(8'd3);
      @(negedge clk);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      wait_bd(200);
      check("busy_in_done", {31'd0, busy}, 32'd0);
      step(5);
      check("b3_launches", 32'(launches_total - batch_base), 32'd3);
      check("b3_batch_done_count", 32'(bd_cnt - bd0), 32'd1);
      check("b3_queue_empty", 32'(exp_q.size()), 32'd0);
      check("b3_busy_after", {31'd0, busy}, 32'd0);
      check("b3_base_idle", {24'd0, feature_base}, 32'd0);

      // write_done gating
      write_done = 1'b0;
      do_start(8'd1);
      step(20);
      check("wd_no_launch", 32'(launches_total - batch_base), 32'd0);
      check("wd_busy", {31'd0, busy}, 32'd1);
      write_done = 1'b1;
      @(negedge clk);
      check("wd_dp_reset_not_yet", {31'd0, dp_reset}, 32'd0);
      @(negedge clk);
      check("wd_dp_reset_next", {31'd0, dp_reset}, 32'd1);
      wait_bd(100);
      step(2);

      // FIFO full back-pressure
      res_ready = 1'b0;
      do_start(8'd6);
      step(100);
      check("full_launches4", 32'(launches_total - batch_base), 32'd4);
      check("full_busy", {31'd0, busy}, 32'd1);
      check("full_res_valid", {31'd0, res_valid}, 32'd1);
      step(20);
      check("full_still4", 32'(launches_total - batch_base), 32'd4);
      res_ready = 1'b1;
      step(1);
      res_ready = 1'b0;
      step(30);
      check("full_launches5", 32'(launches_total - batch_base), 32'd5);
      res_ready = 1'b1;
      wait_bd(200);
      step(5);
      check("full_launches6", 32'(launches_total - batch_base), 32'd6);
      check("full_queue_empty", 32'(exp_q.size()), 32'd0);

      // Zero-length batch
      bd0 = bd_cnt;
      do_start(8'd0);
      @(negedge clk);
      check("zero_batch_done", {31'd0, batch_done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("zero_batch_done_clear", {31'd0, batch_done}, 32'd0);
      check("zero_res_valid", {31'd0, res_valid}, 32'd0);
      step(3);
      check("zero_no_launch", 32'(launches_total - batch_base), 32'd0);

      // Reset mid-RUN on sample 1
      res_ready = 1'b0;
      do_start(8'd3);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (launches_total - batch_base == 2) seen = 1'b1;
      end
      check("mid_second_launch", {31'd0, seen}, 32'd1);
      step(5);
      check("mid_busy", {31'd0, busy}, 32'd1);
      abort_resp = 1'b1;
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_dp_reset", {31'd0, dp_reset}, 32'd0);
      check("mid_rst_base", {24'd0, feature_base}, 32'd0);
      check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("mid_rst_head", {res_sample, res_index[7:0], res_val[15:0]}, 32'd0);
      check("mid_rst_batch_done", {31'd0, batch_done}, 32'd0);
      flush_q = 1'b1;
      step(1);
      flush_q = 1'b0;
      step(15);
      abort_resp = 1'b0;
      check("mid_idle_no_launch", 32'(launches_total - batch_base), 32'd2);
      check("mid_idle_res_valid", {31'd0, res_valid}, 32'd0);
      res_ready = 1'b1;
      do_start(8'd1);
      wait_bd(100);
      step(3);
      check("mid_restart_launch", 32'(launches_total - batch_base), 32'd1);
      check("mid_restart_queue", 32'(exp_q.size()), 32'd0);

`ifdef INFERENCE_SEQ_TIMEOUT_EN
      // Watchdog: no sample_done, 50 RUN cycles per sample
      res_ready = 1'b0;
      no_resp   = 1'b1;
      do_start(8'd2);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (dp_reset) seen = 1'b1;
      end
      check("to_launch_seen", {31'd0, seen}, 32'd1);
      n = 0;
      seen = 1'b0;
      while (n < 100 && !seen) begin
         @(negedge clk);
         n++;
         if (res_valid) seen = 1'b1;
      end
      check("to_latency", 32'(n), 32'd51);
      res_ready = 1'b1;
      wait_bd(300);
      step(3);
      no_resp = 1'b0;
      check("to_launches", 32'(launches_total - batch_base), 32'd2);
      check("to_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
- Multi-sample scheduler sitting above the encoding/similarity datapath in the accelerator top level.
- Once the projection, feature and class memories report loaded, it runs N samples back to back. For each sample it:
  - pulses a datapath reset;
  - presents that sample's feature-memory base address;
  - waits for the similarity checker's done pulse;
  - captures max_index/max_val into a small result FIFO.
- The host drains the FIFO with a valid/ready handshake. A full FIFO holds off the next sample launch.

Parameters:
SAMPLE_WIDTH, 8, width of sample count and sample index
FEA_ADDR_WIDTH, 8, width of feature base address output
SAMPLE_STRIDE, 4, feature-memory words per sample; base = idx*SAMPLE_STRIDE mod 2^FEA_ADDR_WIDTH
RES_DEPTH, 4, result FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 20000, watchdog limit in RUN (used only with INFERENCE_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a batch; honoured only in IDLE
num_samples  in  SAMPLE_WIDTH  batch size, sampled when start is accepted
write_done  in  1  all memories loaded (level)
sample_done  in  1  similarity checker done (1-cycle pulse)
max_val  in  16  checker result value
max_index  in  16  checker winning class index
dp_reset  out  1  1-cycle datapath reset per sample launch
feature_base  out  FEA_ADDR_WIDTH  base address for current sample
busy  out  1  batch in progress
batch_done  out  1  1-cycle pulse after the last sample is captured
res_valid  out  1  FIFO not empty
res_ready  in  1  host pop
res_sample  out  SAMPLE_WIDTH  sample index of head entry
res_index  out  16  head max_index
res_val  out  16  head max_val
res_err  out  1  head entry timed out (0 when feature compiled out)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset behaviour:
  - State returns to IDLE.
  - FIFO is emptied and sample index is cleared.
  - All outputs go to 0.
  - Applies from any state, including mid-batch; an in-flight sample is abandoned and no entry is pushed.
- States: IDLE, WAIT_LOAD, LAUNCH, RUN, DONE.
- IDLE:
  - start=1 and num_samples!=0: latch count, idx=0, go to WAIT_LOAD next cycle, busy=1.
  - start=1 and num_samples==0: go to DONE, with no launch.
  - start is ignored in every other state.
- WAIT_LOAD: go to LAUNCH when write_done=1 and FIFO count<RES_DEPTH. Otherwise stay.
- LAUNCH:
  - dp_reset=1 for exactly this cycle.
  - Go to RUN.
  - sample_done seen during LAUNCH is ignored.
- RUN:
  - On a cycle with sample_done=1, push {idx, max_index, max_val, err=0} at that edge.
  - If idx==count-1, go to DONE. Otherwise idx++ and go to WAIT_LOAD.
- DONE:
  - batch_done=1 for one cycle, busy=0.
  - Go to IDLE.
- Timing:
  - busy is high from the cycle after start is accepted through the cycle before DONE.
  - Minimum per-sample overhead is 3 cycles (WAIT_LOAD, LAUNCH, capture edge).
- feature_base:
  - Registered, equal to idx*SAMPLE_STRIDE truncated to FEA_ADDR_WIDTH (wraps silently).
  - Stable through LAUNCH and RUN.
  - 0 in IDLE.
- FIFO:
  - First-word fall-through; the head is visible while res_valid=1.
  - Pop occurs on res_valid & res_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push never occurs when full: launch is gated on count<RES_DEPTH and only one sample is in flight.
  - res_ready with an empty FIFO has no effect.
  - Pointers wrap modulo RES_DEPTH.
  - Head outputs are 0 when empty.
- write_done deasserting during RUN has no effect. It is checked only in WAIT_LOAD.

Optional Feature:
- Macro: INFERENCE_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN and clears on entering RUN.
  - If the counter reaches TIMEOUT_CYCLES without sample_done, push {idx, 0, 0, err=1}.
  - Then advance exactly as for a normal capture.
  - sample_done on the timeout cycle wins: normal push with err=0.
- Not defined:
  - No counter exists and RUN waits indefinitely.
  - res_err is tied to 0.

Test Plan:
- Reset, then start with num_samples=3, write_done=1, res_ready=1, and sample_done pulsed 10 cycles after each dp_reset:
  - exactly 3 dp_reset pulses;
  - feature_base = 0, 4, 8;
  - res_sample = 0, 1, 2 with matching index/val;
  - batch_done pulses once;
  - busy then drops.
- start while write_done=0 for 20 cycles, then 1: no dp_reset until write_done=1; dp_reset follows 1 cycle after write_done is seen.
- num_samples=6, RES_DEPTH=4, res_ready=0: 4 results captured, then the sequencer stays in WAIT_LOAD. Pop one entry and launch resumes. Final FIFO contents are in order 0..5 after popping.
- num_samples=0: batch_done 1 cycle after start, no dp_reset, res_valid stays 0.
- Reset asserted mid-RUN on sample 1 of 3: all outputs 0 next cycle, FIFO empty. A later start restarts at feature_base=0.
- With INFERENCE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=50, no sample_done: entry {idx 0, res_err=1, index 0, val 0} appears after 50 RUN cycles and the batch continues.
